om_seq_ctrl: RTL and testbench
==============================

# om_seq_ctrl

Sequencer for the online (MSDF) multiplier datapath. Accepts a start command, streams N signed-digit operand pairs into the carry-save residual slices, and handles the online delay DELTA by feeding zero digits for the final DELTA iterations. It collects the slice-selected product digits into a one-entry output buffer with valid/ready backpressure. It sits between the operand digit source and the product digit sink, and drives the enable and init controls of the multiplier slices.

## Interface
- N, default 8: number of operand and product digits; must satisfy N ≥ DELTA+1.
- DELTA, default 3: online delay; number of iterations before the first product digit is valid.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a multiplication; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last product digit handshake.
- in_valid / in_ready  in / out  1 / 1  operand digit-pair handshake.
- in_xd, in_yd  in  2 / 2  operand digits, encoded {pos,neg}: 10=+1, 01=−1, 00=0.
- slice_init  out  1  clears the slice residual (Ws/Wc) registers.
- slice_en  out  1  advances the slices one iteration.
- slice_xd, slice_yd  out  2 / 2  digits presented to the slices.
- slice_z  in  2  digit selected by the top slice in the current iteration; same encoding.
- out_valid / out_ready  out / in  1 / 1  product digit handshake.
- out_z  out  2  product digit.
- err  out  1  sticky illegal-digit flag (see Configuration).

## Operation
- States: IDLE, LOAD (cnt<DELTA), RUN (DELTA≤cnt<N), FLUSH (N≤cnt<N+DELTA), DRAIN (waiting for the last output handshake).
- Iteration counter cnt is ceil(log2(N+DELTA+1)) bits wide. It clears on start and increments on each fire.
- Start acceptance: start=1 in IDLE → slice_init=1 in that same cycle (combinational), cnt←0, err←0, next state LOAD. start outside IDLE is ignored.
- space = !out_valid || out_ready.
- in_ready = (LOAD) || (RUN && space). It never depends on in_valid.
- fire:
  - LOAD: fire = in_valid.
  - RUN: fire = in_valid && space.
  - FLUSH: fire = space.
  - IDLE / DRAIN: fire = 0.
- slice_en = fire.
- slice_xd/yd = in_xd/yd while cnt<N, otherwise 00.
- When fire && cnt≥DELTA, slice_z is captured into out_z and out_valid←1.
- out_valid clears on out_ready unless it is reloaded in the same cycle. A simultaneous drain and load keeps out_valid=1 with the new digit.
- Transitions:
  - LOAD→RUN on the fire at cnt=DELTA−1.
  - RUN→FLUSH on the fire at cnt=N−1.
  - FLUSH→DRAIN on the fire at cnt=N+DELTA−1.
  - DRAIN→IDLE on the out handshake, with done=1 for one cycle.
- Exactly N product digits are emitted per run, in MSDF order.
- Reset values: state=IDLE, cnt=0, busy=0, done=0, out_valid=0, out_z=00, err=0. The combinational outputs in_ready, slice_en and slice_init are 0 in IDLE.
- Reset mid-operation returns to IDLE immediately, discards any buffered digit, and emits no done.

## Timing
- Start accepted at cycle 0; with no stalls, iteration k fires in cycle 1+k.
- Product digit from iteration k is out_valid starting in cycle 2+k. The first one is valid in cycle 2+DELTA.
- Unstalled latency: done in cycle N+DELTA+2 (13 for the defaults); busy is low that same cycle.
- Throughput: one digit per cycle when in_valid=out_ready=1.
- A stall on either side freezes cnt and the slices (slice_en=0). There is no combinational path from out_ready to out_valid.

## Configuration
- OMC_DIGIT_CHK_EN defined:
  - Any consumed digit (fire && cnt<N) equal to 11 on in_xd or in_yd sets err, which stays set until the next accepted start.
  - The offending digit is forwarded to the slices as 00.
- OMC_DIGIT_CHK_EN undefined: err is tied to 0 and digits pass through unchanged.

## Structure
- Package om_pkg holds:
  - digit encoding constants DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00;
  - the state enum om_state_t;
  - a function for the counter width.
- Sub-module om_digit_buf: the one-entry valid/ready output register, with load, data, valid, ready and space ports. The FSM and counter stay in om_seq_ctrl.

## Test plan
- Unstalled run with N=8, DELTA=3 and out_ready=1:
  - in_ready high in cycles 1–8; slice_en high in cycles 1–11; slice_xd/yd=00 in cycles 9–11;
  - out_valid in cycles 5–12 with 8 digits equal to the slice_z values from iterations 3–10;
  - done only in cycle 13.
- Output backpressure: hold out_ready=0 for 4 cycles starting in cycle 6 → slice_en=0 and cnt frozen during the hold; no digit is lost or duplicated; done is delayed by exactly 4 cycles, to cycle 17.
- Input starvation: deassert in_valid in cycles 2–3 → LOAD stalls and out_valid timing shifts by 2; a start pulse while busy is ignored.
- Reset asserted asynchronously during RUN at cnt=5 → all outputs reach their reset values before the next edge; no done. A new start then produces a full 8-digit run.
- With OMC_DIGIT_CHK_EN defined, inject in_xd=11 at iteration 2 → slice_xd=00 that iteration; err=1 from the next cycle through done; err=0 after the next start.
- Boundary N=4, DELTA=3 → LOAD goes directly to RUN for a single iteration; exactly 4 digits are emitted; done in cycle 9.

Source files
------------

// File: rtl/om_pkg.sv
// Shared definitions for the online multiplier sequencer: digit encoding,
// controller states and the iteration-counter width helper.
package om_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } om_state_t;

  // Counter must reach N+DELTA, so it needs ceil(log2(N+DELTA+1)) bits.
  function automatic int om_cnt_width(input int n, input int delta);
    return $clog2(n + delta + 1);
  endfunction

  // {pos,neg} = 11 has no meaning in the signed-digit encoding.
  function automatic logic dig_illegal(input logic [1:0] d);
    return (d == 2'b11);
  endfunction

endpackage

// File: rtl/om_digit_buf.sv
// One-entry valid/ready register holding the next product digit for the sink.
module om_digit_buf
  import om_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] data,
  input  logic       ready,
  output logic       valid,
  output logic       space,
  output logic [1:0] z
);

  assign space = !valid || ready;

  // Load wins over drain, so a same-cycle drain and reload keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      z     <= DIG_ZERO;
    end else if (load) begin
      valid <= 1'b1;
      z     <= data;
    end else if (ready) begin
      valid <= 1'b0;
      z     <= z;
    end else begin
      valid <= valid;
      z     <= z;
    end
  end

endmodule

// File: rtl/om_seq_ctrl.sv
// Sequencer for the MSDF online multiplier: streams operands, flushes DELTA zero digits,
// buffers product digits. Illegal-digit checking is built when OMC_DIGIT_CHK_EN is defined.
module om_seq_ctrl
  import om_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELTA = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_xd,
  input  logic [1:0] in_yd,
  output logic       slice_init,
  output logic       slice_en,
  output logic [1:0] slice_xd,
  output logic [1:0] slice_yd,
  input  logic [1:0] slice_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_z,
  output logic       err
);

  localparam int CW = om_cnt_width(N, DELTA);
  localparam logic [CW-1:0] CNT_N      = CW'(N);
  localparam logic [CW-1:0] CNT_DELTA  = CW'(DELTA);
  localparam logic [CW-1:0] LAST_LOAD  = CW'(DELTA - 1);
  localparam logic [CW-1:0] LAST_RUN   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(N + DELTA - 1);

  om_state_t     state_r;
  om_state_t     state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          space_s;
  logic          fire_s;
  logic          accept_s;
  logic          live_s;
  logic          load_s;
  logic          drain_hs_s;

  assign accept_s   = (state_r == ST_IDLE) && start;
  assign live_s     = (cnt_r < CNT_N);
  assign load_s     = fire_s && (cnt_r >= CNT_DELTA);
  assign drain_hs_s = (state_r == ST_DRAIN) && out_valid && out_ready;
  assign slice_init = accept_s;
  assign slice_en   = fire_s;
  assign in_ready   = (state_r == ST_LOAD) || ((state_r == ST_RUN) && space_s);

  // An iteration fires only when its operands are present and its product digit has room.
  always_comb begin
    fire_s = 1'b0;
    case (state_r)
      ST_LOAD:  fire_s = in_valid;
      ST_RUN:   fire_s = in_valid && space_s;
      ST_FLUSH: fire_s = space_s;
      default:  fire_s = 1'b0;
    endcase
  end

`ifdef OMC_DIGIT_CHK_EN
  logic err_set_s;
  logic err_r;

  // Illegal digits are replaced by zero so the slices never see an undefined value.
  always_comb begin
    slice_xd  = DIG_ZERO;
    slice_yd  = DIG_ZERO;
    err_set_s = 1'b0;
    if (live_s) begin
      slice_xd  = dig_illegal(in_xd) ? DIG_ZERO : in_xd;
      slice_yd  = dig_illegal(in_yd) ? DIG_ZERO : in_yd;
      err_set_s = fire_s && (dig_illegal(in_xd) || dig_illegal(in_yd));
    end else begin
      slice_xd  = DIG_ZERO;
      slice_yd  = DIG_ZERO;
      err_set_s = 1'b0;
    end
  end

  // Sticky until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  // Zero digits feed the slices during the flush iterations.
  always_comb begin
    slice_xd = DIG_ZERO;
    slice_yd = DIG_ZERO;
    if (live_s) begin
      slice_xd = in_xd;
      slice_yd = in_yd;
    end else begin
      slice_xd = DIG_ZERO;
      slice_yd = DIG_ZERO;
    end
  end

  assign err = 1'b0;
`endif

  // Phase transitions are keyed to the fire of the last iteration of each phase.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nxt_s = ST_LOAD;
                else state_nxt_s = ST_IDLE;
      ST_LOAD:  if (fire_s && (cnt_r == LAST_LOAD)) state_nxt_s = ST_RUN;
                else state_nxt_s = ST_LOAD;
      ST_RUN:   if (fire_s && (cnt_r == LAST_RUN)) state_nxt_s = ST_FLUSH;
                else state_nxt_s = ST_RUN;
      ST_FLUSH: if (fire_s && (cnt_r == LAST_FLUSH)) state_nxt_s = ST_DRAIN;
                else state_nxt_s = ST_FLUSH;
      ST_DRAIN: if (drain_hs_s) state_nxt_s = ST_IDLE;
                else state_nxt_s = ST_DRAIN;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, iteration counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done    <= drain_hs_s;
      if (accept_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (fire_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (accept_s) begin
        busy <= 1'b1;
      end else if (drain_hs_s) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
    end
  end

  om_digit_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .data  (slice_z),
    .ready (out_ready),
    .valid (out_valid),
    .space (space_s),
    .z     (out_z)
  );

endmodule

// File: tb/tb_om_seq_ctrl.sv
// Self-checking bench for om_seq_ctrl: a per-cycle vector table for the unstalled run,
// hand-written stall/reset/boundary sequences and a product-digit scoreboard.
module tb_om_seq_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ir;
    logic       init;
    logic       en;
    logic       ov;
    logic       err;
    logic [1:0] sxd;
    logic [1:0] syd;
    logic [1:0] oz;
  } mon_t;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [5:0] exp;  // {in_ready, slice_en, out_valid, done, busy, slice_init}
  } vec_t;

`ifdef OMC_DIGIT_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_xd = 2'b00;
  logic [1:0] in_yd = 2'b00;
  logic [1:0] slice_z = 2'b00;

  logic       a_busy, a_done, a_ir, a_init, a_en, a_ov, a_err;
  logic [1:0] a_sxd, a_syd, a_oz;
  logic       b_busy, b_done, b_ir, b_init, b_en, b_ov, b_err;
  logic [1:0] b_sxd, b_syd, b_oz;
  mon_t       a_mon, b_mon;

  always #5 clk = ~clk;

  om_seq_ctrl #(.N(8), .DELTA(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_ir), .in_xd(in_xd), .in_yd(in_yd),
    .slice_init(a_init), .slice_en(a_en), .slice_xd(a_sxd), .slice_yd(a_syd),
    .slice_z(slice_z), .out_valid(a_ov), .out_ready(out_ready), .out_z(a_oz), .err(a_err)
  );

  om_seq_ctrl #(.N(4), .DELTA(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_ir), .in_xd(in_xd), .in_yd(in_yd),
    .slice_init(b_init), .slice_en(b_en), .slice_xd(b_sxd), .slice_yd(b_syd),
    .slice_z(slice_z), .out_valid(b_ov), .out_ready(out_ready), .out_z(b_oz), .err(b_err)
  );

  assign a_mon = {a_busy, a_done, a_ir, a_init, a_en, a_ov, a_err, a_sxd, a_syd, a_oz};
  assign b_mon = {b_busy, b_done, b_ir, b_init, b_en, b_ov, b_err, b_sxd, b_syd, b_oz};

  int         n_cmp = 0;
  int         n_err = 0;
  logic       sel = 1'b0;
  int         cur_n = 8;
  int         cur_delta = 3;
  int         cyc, iter, pops, done_cnt, done_cyc;
  int         iv_lo, iv_hi, or_lo, or_hi, spur_cyc, inj_iter;
  logic       base_iv, base_or, launch;
  logic [1:0] zt [0:15];
  mon_t       rec [0:63];
  logic [1:0] exp_q [$];
  vec_t       vec [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] rnd_dig();
    case ($urandom_range(0, 2))
      0:       return 2'b10;
      1:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic init_run(input logic s);
    sel = s;
    cur_n = s ? 4 : 8;
    cur_delta = 3;
    cyc = 0; iter = 0; pops = 0; done_cnt = 0; done_cyc = -1;
    iv_lo = 1000; iv_hi = -1; or_lo = 1000; or_hi = -1;
    spur_cyc = -1; inj_iter = -1;
    base_iv = 1'b1; base_or = 1'b1; launch = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) zt[i] = rnd_dig();
  endtask

  // One clock cycle: drive, sample at the falling edge, score, advance.
  task automatic step();
    logic [1:0] xd, yd, ex_x, ex_y, e;
    logic       s;
    mon_t       m;
    s = launch || (cyc == spur_cyc);
    start_a = s && !sel;
    start_b = s && sel;
    in_valid  = base_iv && !(cyc >= iv_lo && cyc <= iv_hi);
    out_ready = base_or && !(cyc >= or_lo && cyc <= or_hi);
    xd = rnd_dig();
    yd = rnd_dig();
    if (iter == inj_iter) xd = 2'b11;
    in_xd = xd;
    in_yd = yd;
    slice_z = zt[iter[3:0]];
    @(negedge clk);
    m = sel ? b_mon : a_mon;
    if (cyc < 64) rec[cyc[5:0]] = m;
    if (m.ov && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got digit 0x%0h, expected no output (cycle %0d)", m.oz, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_digit", 32'(m.oz), 32'(e));
        pops++;
      end
    end
    if (m.en) begin
      ex_x = (iter < cur_n) ? xd : 2'b00;
      ex_y = (iter < cur_n) ? yd : 2'b00;
      if (CHK && xd == 2'b11) ex_x = 2'b00;
      if (CHK && yd == 2'b11) ex_y = 2'b00;
      chk("slice_digits", 32'({m.sxd, m.syd}), 32'({ex_x, ex_y}));
      if (iter >= cur_delta) exp_q.push_back(zt[iter[3:0]]);
      iter++;
    end
    if (m.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch_step();
    launch = 1'b1;
    step();
    launch = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    while (done_cnt == 0 && cyc < limit) step();
    if (done_cnt == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", limit);
    end
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Unstalled N=8/DELTA=3 run, one record per cycle.
    for (int c = 0; c < 14; c++) begin
      vec[c].iv   = 1'b1;
      vec[c].ordy = 1'b1;
      vec[c].exp  = {(c >= 1 && c <= 8), (c >= 1 && c <= 11), (c >= 5 && c <= 12),
                     (c == 13), (c >= 1 && c <= 12), (c == 0)};
    end

    #12;
    chk("reset_a", 32'({a_busy, a_done, a_ir, a_init, a_en, a_ov, a_err, a_oz}), 32'd0);
    chk("reset_b", 32'({b_busy, b_done, b_ir, b_init, b_en, b_ov, b_err, b_oz}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    init_run(1'b0);
    for (int c = 0; c < 14; c++) begin
      base_iv = vec[c].iv;
      base_or = vec[c].ordy;
      launch  = (c == 0);
      step();
      chk($sformatf("tbl_c%0d", c),
          32'({rec[c].ir, rec[c].en, rec[c].ov, rec[c].done, rec[c].busy, rec[c].init}),
          32'(vec[c].exp));
    end
    launch = 1'b0;
    step();
    chk("tbl_pops", 32'(pops), 32'd8);
    chk("tbl_done_cnt", 32'(done_cnt), 32'd1);
    chk("tbl_queue_empty", 32'(exp_q.size()), 32'd0);

    // Output backpressure for cycles 6..9.
    init_run(1'b0);
    or_lo = 6; or_hi = 9;
    launch_step();
    run_until_done(60);
    for (int c = 6; c <= 9; c++)
      chk($sformatf("bp_hold_c%0d", c), 32'({rec[c].en, rec[c].ov}), 32'b01);
    chk("bp_resume", 32'(rec[10].en), 32'd1);
    chk("bp_done_cycle", 32'(done_cyc), 32'd17);
    chk("bp_pops", 32'(pops), 32'd8);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Input starvation in cycles 2..3 plus a start while busy.
    init_run(1'b0);
    iv_lo = 2; iv_hi = 3; spur_cyc = 5;
    launch_step();
    run_until_done(60);
    chk("sv_stall", 32'({rec[2].en, rec[3].en}), 32'd0);
    chk("sv_ready_indep", 32'(rec[2].ir), 32'd1);
    chk("sv_ov_c6", 32'(rec[6].ov), 32'd0);
    chk("sv_ov_c7", 32'(rec[7].ov), 32'd1);
    chk("sv_spur_init", 32'(rec[5].init), 32'd0);
    chk("sv_done_cycle", 32'(done_cyc), 32'd15);
    chk("sv_pops", 32'(pops), 32'd8);

    // Asynchronous reset during RUN at cnt=5.
    init_run(1'b0);
    launch_step();
    while (cyc < 6) step();
    rst = 1'b1;
    #2;
    chk("rst_async", 32'({a_busy, a_done, a_ir, a_init, a_en, a_ov, a_err, a_oz}), 32'd0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    init_run(1'b0);
    launch_step();
    run_until_done(60);
    chk("rst_rerun_done", 32'(done_cyc), 32'd13);
    chk("rst_rerun_pops", 32'(pops), 32'd8);

    // Illegal digit at iteration 2, then the next start clears the flag.
    init_run(1'b0);
    inj_iter = 2;
    launch_step();
    run_until_done(60);
    chk("err_c3", 32'(rec[3].err), 32'd0);
    chk("err_c4", 32'(rec[4].err), 32'(CHK));
    chk("err_done", 32'({rec[13].done, rec[13].err}), 32'({1'b1, CHK}));
    init_run(1'b0);
    launch_step();
    run_until_done(60);
    chk("err_held_idle", 32'(rec[0].err), 32'(CHK));
    chk("err_cleared", 32'(rec[1].err), 32'd0);

    // Boundary N=4, DELTA=3.
    init_run(1'b1);
    launch_step();
    run_until_done(60);
    for (int c = 0; c <= 9; c++)
      chk($sformatf("n4_c%0d", c), 32'({rec[c].ir, rec[c].en, rec[c].ov, rec[c].done}),
          32'({(c >= 1 && c <= 4), (c >= 1 && c <= 7), (c >= 5 && c <= 8), (c == 9)}));
    chk("n4_pops", 32'(pops), 32'd4);
    chk("n4_done_cnt", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
